// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : sw_debouncer
// Description : Synchronises and debounces the board switches. Each bit has a
//               stable-sample counter that advances on a shared prescaler
//               tick. The block provides a clean switch vector, one-cycle
//               rise/fall pulses and, optionally, sticky change flags with
//               an interrupt.
//               Optional feature macro: SW_DEBOUNCER_EDGE_IRQ_EN
//                 defined   -> chg_flags / irq are implemented
//                 undefined -> chg_flags / irq are tied to 0, clr_flags unused
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debouncer #(
    parameter int N_SW           = 16,
    parameter int PRESCALE       = 100000,
    parameter int STABLE_SAMPLES = 10,
    parameter int SYNC_STAGES    = 2
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active low
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] clr_flags,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] chg_flags,
    output logic            irq
);

    localparam int c_PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_CNT_W = $clog2(STABLE_SAMPLES);

    localparam logic [c_PS_W-1:0]  c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES - 1);

    logic [N_SW-1:0]   r_sync [SYNC_STAGES];
    logic [N_SW-1:0]   w_sw_sync;
    logic [c_PS_W-1:0] r_ps_cnt;
    logic              w_tick;
    logic [N_SW-1:0]   w_db;
    logic [N_SW-1:0]   r_db_d;
    logic [N_SW-1:0]   w_rise;
    logic [N_SW-1:0]   w_fall;

    // Multi-stage synchroniser bringing the raw pins into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sw_sync = r_sync[SYNC_STAGES-1];

    // Free-running prescaler; the tick marks the last count of each period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps_cnt <= '0;
        end else if (w_tick) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + c_PS_W'(1);
        end
    end

    assign w_tick = (r_ps_cnt == c_PS_LAST);

    // One stable-sample counter per switch. A sample that agrees with the
    // current debounced value restarts the count, so only an unbroken run of
    // differing samples is able to flip the output.
    generate
        for (genvar i = 0; i < N_SW; i++) begin : g_bit
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_db_bit;

            // Stable-sample counter and debounced bit, advanced on tick only
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt    <= '0;
                    r_db_bit <= 1'b0;
                end else if (w_tick) begin
                    if (w_sw_sync[i] == r_db_bit) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_db_bit <= w_sw_sync[i];
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign w_db[i] = r_db_bit;
        end
    endgenerate

    // Delayed copy of the debounced vector for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= w_db;
        end
    end

    // Both operands are flops, so the pulses are clean for exactly one cycle
    assign w_rise  = w_db & ~r_db_d;
    assign w_fall  = ~w_db & r_db_d;

    assign sw_db   = w_db;
    assign sw_rise = w_rise;
    assign sw_fall = w_fall;

`ifdef SW_DEBOUNCER_EDGE_IRQ_EN
    logic [N_SW-1:0] r_chg;
    logic            r_irq;

    // Sticky change flags; a new edge overrides a coincident clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chg <= '0;
        end else begin
            r_chg <= (r_chg & ~clr_flags) | w_rise | w_fall;
        end
    end

    // Interrupt is the registered OR of all change flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_chg;
        end
    end

    assign chg_flags = r_chg;
    assign irq       = r_irq;
`else
    // Flag logic absent: outputs held low and the clear strobe is ignored
    logic w_unused_clr;

    assign w_unused_clr = ^clr_flags;
    assign chg_flags    = '0;
    assign irq          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debouncer
// Description : Directed self-checking bench for sw_debouncer with
//               PRESCALE = 4, STABLE_SAMPLES = 3, SYNC_STAGES = 2.
//               Flag expectations follow SW_DEBOUNCER_EDGE_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debouncer;

    localparam int N_SW = 16;

`ifdef SW_DEBOUNCER_EDGE_IRQ_EN
    localparam bit c_FLAGS_EN = 1'b1;
`else
    localparam bit c_FLAGS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] clr_flags;
    logic [N_SW-1:0] sw_db;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic [N_SW-1:0] chg_flags;
    logic            irq;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_cnt [N_SW];
    int fall_cnt [N_SW];
    int lat;
    bit ok;

    sw_debouncer #(
        .N_SW           (N_SW),
        .PRESCALE       (4),
        .STABLE_SAMPLES (3),
        .SYNC_STAGES    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .clr_flags (clr_flags),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .chg_flags (chg_flags),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally edge pulses seen there
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N_SW; i++) begin
            rise_cnt[i] += int'(sw_rise[i]);
            fall_cnt[i] += int'(sw_fall[i]);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < N_SW; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    // Step until (sw_db & mask) == val, giving up after limit cycles
    task automatic wait_db(input logic [N_SW-1:0] mask, input logic [N_SW-1:0] val,
                           input int limit, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < limit && !found) begin
            step();
            cycles++;
            if ((sw_db & mask) == val) found = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        sw_raw    = '1;
        clr_flags = '0;
        clear_mon();

        // ---- Reset: everything low while held, then converge to all-ones
        repeat (3) step();
        chk("rst_db",   sw_db,     0);
        chk("rst_rise", sw_rise,   0);
        chk("rst_fall", sw_fall,   0);
        chk("rst_chg",  chg_flags, 0);
        chk("rst_irq",  irq,       0);

        rst = 1'b1;
        clear_mon();
        // sync valid after edge 2, ticks at edges 4, 8, 12 -> flip at edge 12
        wait_db('1, '1, 20, lat, ok);
        chk("rel_found", ok, 1);
        chk("rel_lat",   lat, 12);
        chk("rel_rise",  sw_rise, 16'hFFFF);
        step();
        chk("rel_rise_end", sw_rise, 0);
        chk("rel_flags",    chg_flags, c_FLAGS_EN ? 16'hFFFF : 16'h0000);
        step();
        chk("rel_irq",      irq, c_FLAGS_EN);
        chk("rel_rise_cnt", rise_cnt[15], 1);

        clr_flags = '1;
        step();
        clr_flags = '0;
        chk("rel_clr", chg_flags, 0);

        // ---- Back to an all-zero baseline with flags cleared
        sw_raw = '0;
        wait_db('1, '0, 20, lat, ok);
        chk("base_found", ok, 1);
        step();
        clr_flags = '1;
        step();
        clr_flags = '0;
        step();
        step();
        chk("base_chg", chg_flags, 0);
        chk("base_irq", irq, 0);

        // ---- Clean step on bit 3
        clear_mon();
        sw_raw[3] = 1'b1;
        wait_db(16'h0008, 16'h0008, 20, lat, ok);
        chk("step_found",   ok, 1);
        chk("step_lat_min", lat >= 11, 1);
        chk("step_lat_max", lat <= 14, 1);
        chk("step_rise",    sw_rise, 16'h0008);
        chk("step_db",      sw_db,   16'h0008);
        step();
        chk("step_flag",    chg_flags, c_FLAGS_EN ? 16'h0008 : 16'h0000);
        chk("step_irq_lag", irq, 0);
        step();
        chk("step_irq",     irq, c_FLAGS_EN);
        repeat (5) step();
        chk("step_rise_cnt", rise_cnt[3], 1);
        chk("step_fall_cnt", fall_cnt[3], 0);

        // ---- Clear coinciding with a fall pulse: set wins, then clear works
        clear_mon();
        sw_raw[3] = 1'b0;
        wait_db(16'h0008, 16'h0000, 20, lat, ok);
        chk("cs_found",    ok, 1);
        chk("cs_fall",     sw_fall, 16'h0008);
        chk("cs_pre_flag", chg_flags, c_FLAGS_EN ? 16'h0008 : 16'h0000);
        clr_flags = 16'h0008;
        step();
        chk("cs_set_wins", chg_flags, c_FLAGS_EN ? 16'h0008 : 16'h0000);
        step();
        clr_flags = '0;
        chk("cs_cleared",  chg_flags, 0);
        chk("cs_irq_hold", irq, c_FLAGS_EN);
        step();
        chk("cs_irq_drop", irq, 0);

        // ---- Bounce on bit 0: toggle every 3 cycles for 40 cycles, then hold 1
        clear_mon();
        for (int c = 0; c < 40; c++) begin
            sw_raw[0] = ((c / 3) % 2) == 0;
            step();
        end
        chk("bnc_db_low",  sw_db[0], 0);
        chk("bnc_no_rise", rise_cnt[0], 0);
        sw_raw[0] = 1'b1;
        wait_db(16'h0001, 16'h0001, 20, lat, ok);
        chk("bnc_found", ok, 1);
        chk("bnc_lat",   lat <= 14, 1);
        repeat (6) step();
        chk("bnc_rise_cnt", rise_cnt[0], 1);
        chk("bnc_fall_cnt", fall_cnt[0], 0);
        chk("bnc_db",       sw_db, 16'h0001);
        clr_flags = '1;
        step();
        clr_flags = '0;
        step();

        // ---- Two-cycle glitch on bit 5 is rejected
        clear_mon();
        sw_raw[5] = 1'b1;
        step();
        step();
        sw_raw[5] = 1'b0;
        repeat (20) step();
        chk("gl_db",   sw_db, 16'h0001);
        chk("gl_rise", rise_cnt[5], 0);
        chk("gl_fall", fall_cnt[5], 0);
        chk("gl_chg",  chg_flags, 0);
        chk("gl_irq",  irq, 0);

        // ---- Asynchronous reset with bit 7 two ticks into its count
        sw_raw[7] = 1'b1;
        repeat (10) step();
        chk("ar_pre_db", sw_db, 16'h0001);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_db",   sw_db,     0);
        chk("ar_rise", sw_rise,   0);
        chk("ar_fall", sw_fall,   0);
        chk("ar_chg",  chg_flags, 0);
        chk("ar_irq",  irq,       0);
        repeat (3) step();
        rst = 1'b1;
        clear_mon();
        wait_db('1, 16'h0081, 20, lat, ok);
        chk("ar_found", ok, 1);
        chk("ar_lat",   lat, 12);
        chk("ar_rise",  sw_rise, 16'h0081);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
